cpu_fetch: RTL and testbench

- Instruction fetch unit for the mox125 pipeline, and the producer side of the decode stage's instruction interface (opcode, operand, valid, PC).
- Reads big-endian 16-bit halfwords from instruction memory over a single-outstanding strobe/ack bus.
- Assembles each instruction as a 16-bit opcode plus an optional 32-bit immediate and presents it to decode.
- Honours pipeline stall and redirects on flush/branch.

---
 rtl/cpu_fetch.sv | 156 +++++++++++++++
 tb/tb_cpu_fetch.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch.sv
// mox125 instruction fetch: reads big-endian halfwords over a single-outstanding
// strobe/ack bus and hands 16-bit opcodes plus optional 32-bit immediates to decode.
module cpu_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_1000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] imem_adr_o,
    output logic        imem_stb_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_dat_i,
    output logic [15:0] opcode_o,
    output logic [31:0] operand_o,
    output logic        valid_o,
    output logic [31:0] PC_o
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 16;
    localparam logic [AW-1:0] RST_PC  = RESET_VECTOR & 32'hFFFF_FFFE;
    localparam logic [AW-1:0] HW_STEP = AW'(2);

    typedef enum logic [1:0] {
        S_OP,
        S_HI,
        S_LO,
        S_HOLD
    } state_t;

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic          stb_q;
    logic          pend_flush_q;
    logic [AW-1:0] pend_tgt_q;
    logic [DW-1:0] op_latch_q;
    logic [AW-1:0] op_pc_q;
    logic [DW-1:0] opcode_q;
    logic [AW-1:0] operand_q;
    logic          valid_q;
    logic [AW-1:0] pc_out_q;

    logic [AW-1:0] pc_inc_c;
    logic [AW-1:0] tgt_c;
    logic          take_c;

    assign pc_inc_c = pc_q + HW_STEP;
    assign tgt_c    = branch_target_i & 32'hFFFF_FFFE;
    assign take_c   = stb_q & imem_ack_i;

    // Opcodes that carry a 32-bit immediate; all have bit 15 clear.
    function automatic logic is_long(input logic [DW-1:0] op);
        logic hit;
        case (op[15:8])
            8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
            8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_OP;
            pc_q         <= RST_PC;
            stb_q        <= 1'b1;
            pend_flush_q <= 1'b0;
            pend_tgt_q   <= '0;
            op_latch_q   <= '0;
            op_pc_q      <= '0;
            opcode_q     <= '0;
            operand_q    <= '0;
            valid_q      <= 1'b0;
            pc_out_q     <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            if (stb_q && !imem_ack_i) begin
                // Old request still in flight: remember where to go once it retires.
                pend_flush_q <= 1'b1;
                pend_tgt_q   <= tgt_c;
            end else begin
                pend_flush_q <= 1'b0;
                pc_q         <= tgt_c;
                stb_q        <= 1'b1;
                state_q      <= S_OP;
            end
        end else if (pend_flush_q) begin
            if (take_c) begin
                pend_flush_q <= 1'b0;
                pc_q         <= pend_tgt_q;
                stb_q        <= 1'b1;
                state_q      <= S_OP;
            end
        end else begin
            case (state_q)
                S_OP: begin
                    if (take_c) begin
                        op_latch_q <= imem_dat_i;
                        pc_q       <= pc_inc_c;
                        if (is_long(imem_dat_i)) begin
                            op_pc_q <= pc_q;
                            state_q <= S_HI;
                        end else begin
                            opcode_q  <= imem_dat_i;
                            operand_q <= '0;
                            pc_out_q  <= pc_q;
                            valid_q   <= 1'b1;
                            stb_q     <= 1'b0;
                            state_q   <= S_HOLD;
                        end
                    end
                end
                S_HI: begin
                    if (take_c) begin
                        operand_q[31:16] <= imem_dat_i;
                        pc_q             <= pc_inc_c;
                        state_q          <= S_LO;
                    end
                end
                S_LO: begin
                    if (take_c) begin
                        operand_q[15:0] <= imem_dat_i;
                        opcode_q        <= op_latch_q;
                        pc_out_q        <= op_pc_q;
                        valid_q         <= 1'b1;
                        pc_q            <= pc_inc_c;
                        stb_q           <= 1'b0;
                        state_q         <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall_i) begin
                        valid_q <= 1'b0;
                        stb_q   <= 1'b1;
                        state_q <= S_OP;
                    end
                end
                default: begin
                    state_q <= S_OP;
                    stb_q   <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_adr_o = pc_q;
    assign imem_stb_o = stb_q;
    assign opcode_o   = opcode_q;
    assign operand_o  = operand_q;
    assign valid_o    = valid_q;
    assign PC_o       = pc_out_q;

endmodule

// File: tb/tb_cpu_fetch.sv
// Randomized bench for cpu_fetch: hashed instruction memory with random wait states,
// random stall/flush/reset, and a scoreboard of the expected instruction stream.
module tb_cpu_fetch;

    localparam logic [31:0] RV = 32'h0000_1000;
    localparam int unsigned NCYC = 8000;
    localparam logic [7:0] LONG_OPS [17] = '{
        8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
        8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39};

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] tgt;
    logic [31:0] adr;
    logic        stb;
    logic        ack;
    logic [15:0] dat;
    logic [15:0] opcode;
    logic [31:0] operand;
    logic        valid;
    logic [31:0] pc_o;

    always #5 clk = ~clk;

    cpu_fetch #(.RESET_VECTOR(RV)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .branch_target_i(tgt), .imem_adr_o(adr), .imem_stb_o(stb),
        .imem_ack_i(ack), .imem_dat_i(dat), .opcode_o(opcode),
        .operand_o(operand), .valid_o(valid), .PC_o(pc_o));

    typedef struct {
        logic [31:0] pc;
        logic [15:0] op;
        logic [31:0] opnd;
    } insn_t;

    int unsigned seed;
    int total = 0;
    int bad = 0;
    int transfers = 0;
    int idle = 0;
    bit stim_done = 1'b0;
    insn_t exp_q[$];
    insn_t e_cur;
    logic [31:0] model_pc;

    // Memory contents: fixed program at the reset vector, hashed elsewhere (~40% long opcodes).
    function automatic logic [15:0] hw(input logic [31:0] a);
        logic [31:0] k;
        logic [31:0] h;
        k = a & 32'hFFFF_FFFE;
        case (k)
            32'h1000: return 16'h0212;
            32'h1002: return 16'h0120;
            32'h1004: return 16'hDEAD;
            32'h1006: return 16'hBEEF;
            default: ;
        endcase
        h = (k ^ seed) * 32'h9E37_79B1;
        h = h ^ (h >> 15);
        h = h * 32'h85EB_CA77;
        h = h ^ (h >> 13);
        if (h[7:0] < 8'd102)
            return {LONG_OPS[int'(h[12:8]) % 17], h[23:16]};
        return h[31:16];
    endfunction

    function automatic bit has_imm(input logic [15:0] op);
        foreach (LONG_OPS[i])
            if (op[15:8] == LONG_OPS[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Extend the expected stream from model_pc, walking instruction lengths.
    function automatic void refill();
        insn_t t;
        while (exp_q.size() < 4) begin
            t.pc = model_pc;
            t.op = hw(model_pc);
            if (has_imm(t.op)) begin
                t.opnd = {hw(model_pc + 32'd2), hw(model_pc + 32'd4)};
                model_pc = model_pc + 32'd6;
            end else begin
                t.opnd = 32'd0;
                model_pc = model_pc + 32'd2;
            end
            exp_q.push_back(t);
        end
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endfunction

    function automatic int next_wait(input int c);
        if (c < 60) return 0;
        if (c >= 3000 && c < 3100) return 3;
        if ($urandom_range(0, 1) == 0) return 0;
        return int'($urandom_range(1, 3));
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 3))
            0: return 32'h0000_2001;
            1: return 32'hFFFF_FFFA;
            2: return $urandom;
            default: return RV + 32'($urandom_range(0, 255));
        endcase
    endfunction

    // Stimulus: memory responder plus stall/flush/reset, driven 3 time units after posedge.
    initial begin
        int rst_cnt;
        int wcnt;
        bit quiet;
        seed = $urandom;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; tgt = '0; ack = 1'b0; dat = '0;
        rst_cnt = 3;
        wcnt = 0;
        for (int c = 0; c < int'(NCYC); c++) begin
            @(posedge clk);
            #2;
            if (rst_cnt > 0) begin
                rst_cnt--;
                if (rst_cnt == 0) begin
                    rst = 1'b0;
                    wcnt = next_wait(c);
                end
            end else if (c == 2998 || $urandom_range(0, 1499) == 0) begin
                rst = 1'b1;
                rst_cnt = 2;
            end
            #1;
            if (rst) begin
                ack = 1'b0; stall = 1'b0; flush = 1'b0;
            end else begin
                if (stb) begin
                    if (wcnt == 0) begin
                        ack = 1'b1; dat = hw(adr); wcnt = next_wait(c);
                    end else begin
                        ack = 1'b0; dat = 16'($urandom); wcnt--;
                    end
                end else begin
                    ack = ($urandom_range(0, 7) == 0);
                    dat = 16'($urandom);
                end
                quiet = (c < 60) || (c >= 2998 && c < 3100);
                stall = !quiet && ($urandom_range(0, 99) < 30);
                flush = !quiet && ($urandom_range(0, 99) < 4);
                tgt   = pick_target();
            end
        end
        @(posedge clk);
        stim_done = 1'b1;
    end

    // Monitor: sampled on the falling edge, where inputs for the next posedge are settled.
    logic        p_wait, p_stall, p_flush, p_xfer;
    logic [31:0] p_adr, p_operand, p_pc;
    logic [15:0] p_opcode;
    logic        xfer;

    always @(negedge clk) begin
        if (stim_done) begin
            chk("progress", 32'(transfers >= 100), 32'd1);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
        if (rst) begin
            chk("rst_valid", 32'(valid), 32'd0);
            chk("rst_adr", adr, RV);
            chk("rst_stb", 32'(stb), 32'd1);
            chk("rst_opcode", 32'(opcode), 32'd0);
            chk("rst_operand", operand, 32'd0);
            chk("rst_pc", pc_o, 32'd0);
            model_pc = RV;
            exp_q.delete();
            refill();
            p_wait = 1'b0; p_stall = 1'b0; p_flush = 1'b0; p_xfer = 1'b0;
            idle = 0;
        end else begin
            if (p_wait) begin
                chk("adr_stable", adr, p_adr);
                chk("stb_held", 32'(stb), 32'd1);
            end
            if (p_stall) begin
                chk("stall_valid", 32'(valid), 32'd1);
                chk("stall_opcode", 32'(opcode), 32'(p_opcode));
                chk("stall_operand", operand, p_operand);
                chk("stall_pc", pc_o, p_pc);
                chk("stall_stb", 32'(stb), 32'd0);
            end
            if (p_flush) chk("flush_valid", 32'(valid), 32'd0);
            if (p_xfer) begin
                chk("xfer_valid_drop", 32'(valid), 32'd0);
                chk("xfer_stb", 32'(stb), 32'd1);
                chk("xfer_next_adr", adr, exp_q[0].pc);
            end
            xfer = valid && !stall && !flush;
            if (xfer) begin
                e_cur = exp_q.pop_front();
                chk("insn_pc", pc_o, e_cur.pc);
                chk("insn_opcode", 32'(opcode), 32'(e_cur.op));
                chk("insn_operand", operand, e_cur.opnd);
                transfers++;
                refill();
                idle = 0;
            end else begin
                idle++;
            end
            if (flush) begin
                model_pc = tgt & 32'hFFFF_FFFE;
                exp_q.delete();
                refill();
            end
            if (idle > 400) begin
                total++;
                bad++;
                $display("FAIL watchdog: got no transfer for %0d cycles want <=400", idle);
                idle = 0;
            end
            p_wait    = stb && !ack;
            p_adr     = adr;
            p_stall   = valid && stall && !flush;
            p_opcode  = opcode;
            p_operand = operand;
            p_pc      = pc_o;
            p_flush   = flush;
            p_xfer    = xfer;
        end
    end

endmodule
